// File: rtl/tug_pkg.sv
// Shared types and helpers for the tug-of-war playfield.
// Default-build CENTER/MATCH_PT live here; instances derive their own via the helper functions.
package tug_pkg;

    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        HOLD_L = 2'd1,
        HOLD_R = 2'd2,
        MATCH  = 2'd3
    } tug_state_t;

    localparam int N_LEDS_DEF  = 10;
    localparam int SCORE_W_DEF = 3;
    localparam int CENTER      = N_LEDS_DEF / 2;
    localparam int MATCH_PT    = (1 << SCORE_W_DEF) - 1;

    function automatic int center_of(input int n);
        return n / 2;
    endfunction

    function automatic int match_pt_of(input int w);
        return (1 << w) - 1;
    endfunction

    // One-hot of pos, masked to an n-position bar (n <= 32).
    function automatic logic [31:0] onehot(input logic [4:0] pos, input int n);
        logic [31:0] v;
        v = 32'd1 << pos;
        if (n < 32) begin
            v = v & ((32'd1 << n) - 32'd1);
        end else begin
            v = v;
        end
        return v;
    endfunction

endpackage

// File: rtl/tug_playfield_if.sv
// Player pulses in, display/score/match status out.
interface tug_playfield_if #(
    parameter int N_LEDS  = 10,
    parameter int SCORE_W = 3
) ();
    logic               Rin;
    logic               Lin;
    logic               serve;
    logic [N_LEDS-1:0]  LED;
    logic [SCORE_W-1:0] l_score;
    logic [SCORE_W-1:0] r_score;
    logic               match_over;
    logic               winner;

    modport master (
        output Rin, Lin, serve,
        input  LED, l_score, r_score, match_over, winner
    );

    modport slave (
        input  Rin, Lin, serve,
        output LED, l_score, r_score, match_over, winner
    );
endinterface

// File: rtl/tug_score_ctr.sv
// Saturating per-player score counter; will_win flags the point that reaches match point.
module tug_score_ctr
    import tug_pkg::*;
#(
    parameter int SCORE_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               clr,
    output logic [SCORE_W-1:0] count,
    output logic               will_win
);
    localparam logic [SCORE_W-1:0] TOP  = SCORE_W'(match_pt_of(SCORE_W));
    localparam logic [SCORE_W-1:0] NEAR = SCORE_W'(match_pt_of(SCORE_W) - 1);

    // Score register: clear beats increment, and it never wraps past match point.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != TOP)) begin
            count <= count + SCORE_W'(1);
        end else begin
            count <= count;
        end
    end

    assign will_win = inc && (count == NEAR);

endmodule

// File: rtl/tug_playfield.sv
// Tug-of-war playfield: light position, point detection, hold/serve and match control.
// LED is decoded from next-state/next-pos so display tracks state with no extra latency.
module tug_playfield
    import tug_pkg::*;
#(
    parameter int N_LEDS  = 10,
    parameter int SCORE_W = 3
) (
    input  logic           clk,
    input  logic           reset,
    tug_playfield_if.slave bus
);
    localparam int PW = $clog2(N_LEDS);
    localparam logic [PW-1:0]     POS_CENTER = PW'(center_of(N_LEDS));
    localparam logic [PW-1:0]     POS_LAST   = PW'(N_LEDS - 1);
    localparam logic [N_LEDS-1:0] LOW_HALF   = {{(N_LEDS/2){1'b0}}, {(N_LEDS/2){1'b1}}};
    localparam logic [N_LEDS-1:0] LED_RESET  = {{(N_LEDS-1){1'b0}}, 1'b1} << POS_CENTER;

    tug_state_t        state_r, next_state;
    logic [PW-1:0]     pos_r, next_pos;
    logic              winner_r, next_winner;
    logic              match_over_r;
    logic [N_LEDS-1:0] led_r, next_led;
    logic              inc_l, inc_r, clr_scores;
    logic              l_will_win, r_will_win;

    tug_score_ctr #(.SCORE_W(SCORE_W)) u_l_score (
        .clk      (clk),
        .reset    (reset),
        .inc      (inc_l),
        .clr      (clr_scores),
        .count    (bus.l_score),
        .will_win (l_will_win)
    );

    tug_score_ctr #(.SCORE_W(SCORE_W)) u_r_score (
        .clk      (clk),
        .reset    (reset),
        .inc      (inc_r),
        .clr      (clr_scores),
        .count    (bus.r_score),
        .will_win (r_will_win)
    );

    // Next-state, next-position, scoring strobes and winner selection.
    always_comb begin
        next_state  = state_r;
        next_pos    = pos_r;
        next_winner = winner_r;
        inc_l       = 1'b0;
        inc_r       = 1'b0;
        clr_scores  = 1'b0;
        case (state_r)
            PLAY: begin
                if (bus.Rin && !bus.Lin) begin
                    if (pos_r == '0) begin
                        inc_r = 1'b1;
                        if (r_will_win) begin
                            next_state  = MATCH;
                            next_winner = 1'b1;
                        end else begin
                            next_state = HOLD_R;
                        end
                    end else begin
                        next_pos = pos_r - PW'(1);
                    end
                end else if (bus.Lin && !bus.Rin) begin
                    if (pos_r == POS_LAST) begin
                        inc_l = 1'b1;
                        if (l_will_win) begin
                            next_state  = MATCH;
                            next_winner = 1'b0;
                        end else begin
                            next_state = HOLD_L;
                        end
                    end else begin
                        next_pos = pos_r + PW'(1);
                    end
                end else begin
                    next_pos = pos_r;
                end
            end
            HOLD_L, HOLD_R: begin
                if (bus.serve) begin
                    next_state = PLAY;
                    next_pos   = POS_CENTER;
                end else begin
                    next_state = state_r;
                end
            end
            MATCH: begin
                if (bus.serve) begin
                    next_state  = PLAY;
                    next_pos    = POS_CENTER;
                    next_winner = 1'b0;
                    clr_scores  = 1'b1;
                end else begin
                    next_state = MATCH;
                end
            end
            default: begin
                next_state = PLAY;
                next_pos   = POS_CENTER;
            end
        endcase
    end

    // Display pattern for the state being entered.
    always_comb begin
        next_led = N_LEDS'(onehot(5'(next_pos), N_LEDS));
        case (next_state)
            PLAY:    next_led = N_LEDS'(onehot(5'(next_pos), N_LEDS));
            HOLD_R:  next_led = LOW_HALF;
            HOLD_L:  next_led = ~LOW_HALF;
            MATCH:   next_led = '1;
            default: next_led = LED_RESET;
        endcase
    end

    // State, position and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= PLAY;
            pos_r        <= POS_CENTER;
            winner_r     <= 1'b0;
            match_over_r <= 1'b0;
            led_r        <= LED_RESET;
        end else begin
            state_r      <= next_state;
            pos_r        <= next_pos;
            winner_r     <= next_winner;
            match_over_r <= (next_state == MATCH);
            led_r        <= next_led;
        end
    end

    assign bus.LED        = led_r;
    assign bus.winner     = winner_r;
    assign bus.match_over = match_over_r;

endmodule

// File: tb/tb_tug_playfield.sv
// Directed bench: default build (10 LEDs, 3-bit scores) and a 16-LED/2-bit build side by side.
module tb_tug_playfield;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    tug_playfield_if #(.N_LEDS(10), .SCORE_W(3)) ifa ();
    tug_playfield_if #(.N_LEDS(16), .SCORE_W(2)) ifb ();

    tug_playfield #(.N_LEDS(10), .SCORE_W(3)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
    tug_playfield #(.N_LEDS(16), .SCORE_W(2)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

    // Inputs are applied just after a negedge and held for one full cycle.
    task automatic step_a(input logic r, input logic l, input logic s);
        ifa.Rin = r; ifa.Lin = l; ifa.serve = s;
        @(negedge clk);
        ifa.Rin = 1'b0; ifa.Lin = 1'b0; ifa.serve = 1'b0;
    endtask

    task automatic step_b(input logic r, input logic l, input logic s);
        ifb.Rin = r; ifb.Lin = l; ifb.serve = s;
        @(negedge clk);
        ifb.Rin = 1'b0; ifb.Lin = 1'b0; ifb.serve = 1'b0;
    endtask

    task automatic test_reset;
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.Rin = 1'b0; ifa.Lin = 1'b0; ifa.serve = 1'b0;
        ifb.Rin = 1'b0; ifb.Lin = 1'b0; ifb.serve = 1'b0;
        #1;
        n_total++; if (ifa.LED !== 10'd32) $display("FAIL reset_led_a: got %0d expected 32", ifa.LED); else n_pass++;
        n_total++; if (ifa.l_score !== 3'd0 || ifa.r_score !== 3'd0) $display("FAIL reset_scores_a: got l=%0d r=%0d expected 0/0", ifa.l_score, ifa.r_score); else n_pass++;
        n_total++; if (ifa.match_over !== 1'b0 || ifa.winner !== 1'b0) $display("FAIL reset_match_a: got mo=%b w=%b expected 0/0", ifa.match_over, ifa.winner); else n_pass++;
        n_total++; if (ifb.LED !== 16'd256) $display("FAIL reset_led_b: got %0d expected 256", ifb.LED); else n_pass++;
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        n_total++; if (ifa.LED !== 10'd32) $display("FAIL idle_led_a: got %0d expected 32", ifa.LED); else n_pass++;
    endtask

    task automatic test_walk_a;
        for (int i = 1; i <= 5; i++) begin
            step_a(1'b1, 1'b0, 1'b0);
            n_total++; if (ifa.LED !== (10'd32 >> i)) $display("FAIL walk_led_a[%0d]: got %0d expected %0d", i, ifa.LED, 10'd32 >> i); else n_pass++;
        end
        n_total++; if (ifa.l_score !== 3'd0 || ifa.r_score !== 3'd0) $display("FAIL walk_scores_a: got l=%0d r=%0d expected 0/0", ifa.l_score, ifa.r_score); else n_pass++;
    endtask

    task automatic test_score_hold_a;
        step_a(1'b1, 1'b0, 1'b0);
        n_total++; if (ifa.r_score !== 3'd1) $display("FAIL score_r_a: got %0d expected 1", ifa.r_score); else n_pass++;
        n_total++; if (ifa.LED !== 10'b0000011111) $display("FAIL hold_r_led_a: got %b expected 0000011111", ifa.LED); else n_pass++;
        step_a(1'b0, 1'b1, 1'b0);
        n_total++; if (ifa.LED !== 10'b0000011111 || ifa.l_score !== 3'd0) $display("FAIL hold_ignore_a: got led=%b l=%0d expected 0000011111/0", ifa.LED, ifa.l_score); else n_pass++;
        step_a(1'b1, 1'b0, 1'b1);
        n_total++; if (ifa.LED !== 10'd32 || ifa.r_score !== 3'd1) $display("FAIL serve_wins_a: got led=%0d r=%0d expected 32/1", ifa.LED, ifa.r_score); else n_pass++;
        step_a(1'b1, 1'b0, 1'b0);
        n_total++; if (ifa.LED !== 10'd16) $display("FAIL first_move_a: got %0d expected 16", ifa.LED); else n_pass++;
    endtask

    task automatic test_both_ends_a;
        repeat (5) step_a(1'b0, 1'b1, 1'b0);
        n_total++; if (ifa.LED !== 10'd512) $display("FAIL left_end_a: got %0d expected 512", ifa.LED); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step_a(1'b1, 1'b1, 1'b0);
            n_total++; if (ifa.LED !== 10'd512 || ifa.l_score !== 3'd0 || ifa.r_score !== 3'd1) $display("FAIL both_a[%0d]: got led=%0d l=%0d r=%0d expected 512/0/1", i, ifa.LED, ifa.l_score, ifa.r_score); else n_pass++;
        end
        step_a(1'b0, 1'b1, 1'b0);
        n_total++; if (ifa.l_score !== 3'd1 || ifa.LED !== 10'b1111100000) $display("FAIL score_l_a: got l=%0d led=%b expected 1/1111100000", ifa.l_score, ifa.LED); else n_pass++;
        step_a(1'b0, 1'b0, 1'b1);
        n_total++; if (ifa.LED !== 10'd32) $display("FAIL serve_l_a: got %0d expected 32", ifa.LED); else n_pass++;
    endtask

    task automatic test_match_a;
        repeat (5) begin
            repeat (6) step_a(1'b1, 1'b0, 1'b0);
            step_a(1'b0, 1'b0, 1'b1);
        end
        n_total++; if (ifa.r_score !== 3'd6 || ifa.match_over !== 1'b0) $display("FAIL six_points_a: got r=%0d mo=%b expected 6/0", ifa.r_score, ifa.match_over); else n_pass++;
        repeat (6) step_a(1'b1, 1'b0, 1'b0);
        n_total++; if (ifa.r_score !== 3'd7 || ifa.match_over !== 1'b1 || ifa.winner !== 1'b1) $display("FAIL match_a: got r=%0d mo=%b w=%b expected 7/1/1", ifa.r_score, ifa.match_over, ifa.winner); else n_pass++;
        n_total++; if (ifa.LED !== 10'h3FF) $display("FAIL match_led_a: got %b expected all ones", ifa.LED); else n_pass++;
        step_a(1'b1, 1'b0, 1'b0);
        n_total++; if (ifa.LED !== 10'h3FF || ifa.r_score !== 3'd7) $display("FAIL match_ignore_a: got led=%0d r=%0d expected 1023/7", ifa.LED, ifa.r_score); else n_pass++;
        step_a(1'b0, 1'b0, 1'b1);
        n_total++; if (ifa.l_score !== 3'd0 || ifa.r_score !== 3'd0 || ifa.LED !== 10'd32) $display("FAIL rematch_a: got l=%0d r=%0d led=%0d expected 0/0/32", ifa.l_score, ifa.r_score, ifa.LED); else n_pass++;
        n_total++; if (ifa.match_over !== 1'b0 || ifa.winner !== 1'b0) $display("FAIL rematch_flags_a: got mo=%b w=%b expected 0/0", ifa.match_over, ifa.winner); else n_pass++;
    endtask

    task automatic test_async_reset_a;
        repeat (2) begin
            repeat (5) step_a(1'b0, 1'b1, 1'b0);
            step_a(1'b0, 1'b0, 1'b1);
        end
        repeat (5) step_a(1'b0, 1'b1, 1'b0);
        n_total++; if (ifa.l_score !== 3'd3 || ifa.LED !== 10'b1111100000) $display("FAIL pre_reset_a: got l=%0d led=%b expected 3/1111100000", ifa.l_score, ifa.LED); else n_pass++;
        #1 rst_a = 1'b1;
        #1;
        n_total++; if (ifa.LED !== 10'd32 || ifa.l_score !== 3'd0 || ifa.r_score !== 3'd0) $display("FAIL async_reset_a: got led=%0d l=%0d r=%0d expected 32/0/0", ifa.LED, ifa.l_score, ifa.r_score); else n_pass++;
        #1 rst_a = 1'b0;
        @(negedge clk);
        step_a(1'b0, 1'b1, 1'b0);
        n_total++; if (ifa.LED !== 10'd64) $display("FAIL post_reset_move_a: got %0d expected 64", ifa.LED); else n_pass++;
    endtask

    task automatic test_wide_b;
        for (int i = 1; i <= 5; i++) begin
            step_b(1'b1, 1'b0, 1'b0);
            n_total++; if (ifb.LED !== (16'd256 >> i)) $display("FAIL walk_led_b[%0d]: got %0d expected %0d", i, ifb.LED, 16'd256 >> i); else n_pass++;
        end
        repeat (3) step_b(1'b1, 1'b0, 1'b0);
        n_total++; if (ifb.LED !== 16'd1) $display("FAIL right_end_b: got %0d expected 1", ifb.LED); else n_pass++;
        step_b(1'b1, 1'b0, 1'b0);
        n_total++; if (ifb.r_score !== 2'd1 || ifb.LED !== 16'h00FF) $display("FAIL hold_r_b: got r=%0d led=%h expected 1/00ff", ifb.r_score, ifb.LED); else n_pass++;
        step_b(1'b0, 1'b0, 1'b1);
        n_total++; if (ifb.LED !== 16'd256) $display("FAIL serve_b: got %0d expected 256", ifb.LED); else n_pass++;
        repeat (9) step_b(1'b1, 1'b0, 1'b0);
        n_total++; if (ifb.r_score !== 2'd2 || ifb.match_over !== 1'b0) $display("FAIL two_points_b: got r=%0d mo=%b expected 2/0", ifb.r_score, ifb.match_over); else n_pass++;
        step_b(1'b0, 1'b0, 1'b1);
        repeat (9) step_b(1'b1, 1'b0, 1'b0);
        n_total++; if (ifb.r_score !== 2'd3 || ifb.match_over !== 1'b1 || ifb.winner !== 1'b1 || ifb.LED !== 16'hFFFF) $display("FAIL match_r_b: got r=%0d mo=%b w=%b led=%h expected 3/1/1/ffff", ifb.r_score, ifb.match_over, ifb.winner, ifb.LED); else n_pass++;
        step_b(1'b0, 1'b0, 1'b1);
        n_total++; if (ifb.r_score !== 2'd0 || ifb.LED !== 16'd256 || ifb.match_over !== 1'b0) $display("FAIL rematch_b: got r=%0d led=%0d mo=%b expected 0/256/0", ifb.r_score, ifb.LED, ifb.match_over); else n_pass++;
        repeat (2) begin
            repeat (8) step_b(1'b0, 1'b1, 1'b0);
            step_b(1'b0, 1'b0, 1'b1);
        end
        repeat (8) step_b(1'b0, 1'b1, 1'b0);
        n_total++; if (ifb.l_score !== 2'd3 || ifb.match_over !== 1'b1 || ifb.winner !== 1'b0 || ifb.LED !== 16'hFFFF) $display("FAIL match_l_b: got l=%0d mo=%b w=%b led=%h expected 3/1/0/ffff", ifb.l_score, ifb.match_over, ifb.winner, ifb.LED); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_walk_a();
        test_score_hold_a();
        test_both_ends_a();
        test_match_a();
        test_async_reset_a();
        test_wide_b();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
